// File: rtl/player_ctrl.sv
// player_ctrl
// Per-player controller for the tennis/squash game core. Converts rising
// edges of the player button into ball returns or penalised whiffs, keeps a
// configurable life budget, applies a swing cooldown after each whiff and
// flags the end of the match.
//
// Parameters:
//   LIVES     lives loaded at reset and at every new game (1..15)
//   LIFE_W    width of life; must hold LIVES
//   COOLDOWN  cycles after a whiff during which swings are ignored (0 = none)
//   MISS_MODE 0 = a missed ball ends the match, 1 = a missed ball costs a life
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   en            block enable; low freezes all state and forces ret low
//   start_game    game active level; low forces a fresh game in IDLE
//   button        synchronised, debounced player button level
//   hittable_ball high while the ball is inside this player's hit window
//   ret           one-cycle pulse: the ball was returned
//   life          remaining lives
//   match         player has lost; held while in OVER
//   cooling       high while the cooldown counter is non-zero

module player_ctrl #(
  parameter int LIVES     = 3,
  parameter int LIFE_W    = 4,
  parameter int COOLDOWN  = 4,
  parameter int MISS_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start_game,
  input  logic              button,
  input  logic              hittable_ball,
  output logic              ret,
  output logic [LIFE_W-1:0] life,
  output logic              match,
  output logic              cooling
);

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [LIFE_W-1:0] LIVES_L = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] ONE_L   = LIFE_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    WINDOW,
    HIT,
    OVER
  } state_t;

  state_t          state;
  logic            button_q;
  logic [CD_W-1:0] cd_cnt;
  logic [CD_W-1:0] cd_dec;
  logic            swing;
  logic            accepted;

  // The button history register runs even while disabled, so re-enabling
  // compares against the current level and never sees a stale edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_q <= 1'b0;
    end else begin
      button_q <= button;
    end
  end

  assign swing    = button & ~button_q;
  assign accepted = swing & ~cooling;

  // Saturating cooldown decrement used on every enabled cycle unless a whiff
  // reloads the counter.
  always_comb begin
    cd_dec = cd_cnt;
    if (cd_cnt != '0) begin
      cd_dec = cd_cnt - CD_W'(1);
    end
  end

  // Main game FSM. ret defaults low every cycle, including frozen ones.
  // A low start_game overrides every other event and starts a fresh game.
  // The decrement that empties life happens on the same edge as entry to
  // OVER, so life reads 0 while match is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ret     <= 1'b0;
      life    <= LIVES_L;
      match   <= 1'b0;
      cd_cnt  <= '0;
      cooling <= 1'b0;
    end else begin
      ret <= 1'b0;
      if (en) begin
        if (!start_game) begin
          state   <= IDLE;
          life    <= LIVES_L;
          match   <= 1'b0;
          cd_cnt  <= '0;
          cooling <= 1'b0;
        end else begin
          cd_cnt  <= cd_dec;
          cooling <= (cd_dec != '0);
          case (state)
            IDLE: begin
              state <= READY;
            end
            READY: begin
              if (hittable_ball && accepted) begin
                ret   <= 1'b1;
                state <= HIT;
              end else if (hittable_ball) begin
                state <= WINDOW;
              end else if (accepted) begin
                cd_cnt  <= CD_LOAD;
                cooling <= (COOLDOWN != 0);
                if (life != '0) begin
                  life <= life - ONE_L;
                end
                if (life <= ONE_L) begin
                  match <= 1'b1;
                  state <= OVER;
                end
              end
            end
            WINDOW: begin
              // A swing on the falling edge of the window is a miss only.
              if (!hittable_ball) begin
                if (MISS_MODE == 0) begin
                  match <= 1'b1;
                  state <= OVER;
                end else begin
                  if (life != '0) begin
                    life <= life - ONE_L;
                  end
                  if (life <= ONE_L) begin
                    match <= 1'b1;
                    state <= OVER;
                  end else begin
                    state <= READY;
                  end
                end
              end else if (accepted) begin
                ret   <= 1'b1;
                state <= HIT;
              end
            end
            HIT: begin
              if (!hittable_ball) begin
                state <= READY;
              end
            end
            OVER: begin
              match <= 1'b1;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl
// Scoreboard bench for player_ctrl. Two instances share all inputs:
//   dut0: defaults (LIVES=3, COOLDOWN=4, MISS_MODE=0)
//   dut1: LIVES=2, COOLDOWN=2, MISS_MODE=1
// The stimulus process drives inputs on the falling edge, steps an
// event-level reference model and pushes the expected outputs; a separate
// monitor pops and compares one entry after every rising edge.

module tb_player_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start_game;
  logic       button;
  logic       hittable_ball;
  logic       ret0, ret1;
  logic [3:0] life0, life1;
  logic       match0, match1;
  logic       cooling0, cooling1;

  typedef struct packed {
    logic       ret;
    logic [3:0] life;
    logic       match;
    logic       cooling;
  } obs_t;
  typedef obs_t [1:0] pair_t;

  pair_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  bit    started    = 0;

  // Model parameters, one entry per instance
  int p_lives[2] = '{3, 2};
  int p_cd[2]    = '{4, 2};
  int p_mm[2]    = '{0, 1};

  // Model state: game flags, lives, and cooldown as an end point on a count
  // of enabled cycles
  bit m_prev_btn;
  bit m_in_game[2];
  bit m_window[2];
  bit m_returned[2];
  bit m_lost[2];
  bit m_ret[2];
  int m_life[2];
  int m_en_cyc[2];
  int m_cool_end[2];

  player_ctrl u_dut0 (
    .clk(clk), .rst(rst), .en(en), .start_game(start_game),
    .button(button), .hittable_ball(hittable_ball),
    .ret(ret0), .life(life0), .match(match0), .cooling(cooling0)
  );

  player_ctrl #(.LIVES(2), .LIFE_W(4), .COOLDOWN(2), .MISS_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .start_game(start_game),
    .button(button), .hittable_ball(hittable_ball),
    .ret(ret1), .life(life1), .match(match1), .cooling(cooling1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pair_t actualPair();
    pair_t r;
    r[0] = {ret0, life0, match0, cooling0};
    r[1] = {ret1, life1, match1, cooling1};
    return r;
  endfunction

  function automatic pair_t expectedPair();
    pair_t r;
    for (int d = 0; d < 2; d++) begin
      r[d].ret     = m_ret[d];
      r[d].life    = 4'(m_life[d]);
      r[d].match   = m_lost[d];
      r[d].cooling = (m_cool_end[d] > m_en_cyc[d]);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_prev_btn = 0;
    for (int d = 0; d < 2; d++) begin
      m_in_game[d]  = 0;
      m_window[d]   = 0;
      m_returned[d] = 0;
      m_lost[d]     = 0;
      m_ret[d]      = 0;
      m_life[d]     = p_lives[d];
      m_cool_end[d] = m_en_cyc[d];
    end
  endtask

  task automatic loseLife(input int d);
    if (m_life[d] > 0) m_life[d]--;
    if (m_life[d] == 0) m_lost[d] = 1;
  endtask

  // One clock edge of the game rules, applied to both configurations
  task automatic modelStep(input bit sg, input bit btn, input bit hb, input bit e);
    bit swing;
    bit cool_now;
    bit acc;
    swing = btn && !m_prev_btn;
    m_prev_btn = btn;
    for (int d = 0; d < 2; d++) begin
      m_ret[d] = 0;
      if (!e) continue;
      cool_now = (m_cool_end[d] > m_en_cyc[d]);
      acc = swing && !cool_now;
      m_en_cyc[d]++;
      if (!sg) begin
        m_in_game[d]  = 0;
        m_window[d]   = 0;
        m_returned[d] = 0;
        m_lost[d]     = 0;
        m_life[d]     = p_lives[d];
        m_cool_end[d] = m_en_cyc[d];
      end else if (!m_in_game[d]) begin
        m_in_game[d] = 1;
      end else if (m_lost[d]) begin
        // match lost: everything ignored until the game drops
      end else if (m_returned[d]) begin
        if (!hb) m_returned[d] = 0;
      end else if (m_window[d]) begin
        if (!hb) begin
          m_window[d] = 0;
          if (p_mm[d] == 0) m_lost[d] = 1;
          else loseLife(d);
        end else if (acc) begin
          m_ret[d] = 1;
          m_returned[d] = 1;
          m_window[d] = 0;
        end
      end else begin
        if (hb && acc) begin
          m_ret[d] = 1;
          m_returned[d] = 1;
        end else if (hb) begin
          m_window[d] = 1;
        end else if (acc) begin
          loseLife(d);
          m_cool_end[d] = m_en_cyc[d] + p_cd[d];
        end
      end
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and return
  // at the next falling edge with the DUT outputs for that cycle visible.
  task automatic applyStimulus(input bit sg, input bit btn, input bit hb, input bit e = 1'b1);
    start_game    = sg;
    button        = btn;
    hittable_ball = hb;
    en            = e;
    modelStep(sg, btn, hb, e);
    exp_q.push_back(expectedPair());
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must return to reset values with no edge
  task automatic resetPulse();
    pair_t a;
    rst = 1'b1;
    modelReset();
    #1;
    a = actualPair();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_life_dut%0d", d), int'(a[d].life), p_lives[d]);
      checkOutput($sformatf("reset_match_dut%0d", d), int'(a[d].match), 0);
      checkOutput($sformatf("reset_ret_dut%0d", d), int'(a[d].ret), 0);
      checkOutput($sformatf("reset_cooling_dut%0d", d), int'(a[d].cooling), 0);
    end
    exp_q.push_back(expectedPair());
    started = 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle the DUTs present a full output set; compare it
  // against the oldest queued expectation.
  initial begin
    pair_t e;
    pair_t a;
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_underflow: got empty queue, want an entry (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        a = actualPair();
        for (int d = 0; d < 2; d++) begin
          compared++;
          if (a[d] != e[d]) begin
            mismatched++;
            $display("[TB] FAIL cycle_dut%0d (t=%0t): got ret=%0b life=%0d match=%0b cooling=%0b, want ret=%0b life=%0d match=%0b cooling=%0b",
                     d, $time, a[d].ret, a[d].life, a[d].match, a[d].cooling,
                     e[d].ret, e[d].life, e[d].match, e[d].cooling);
          end
        end
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    int ret_cnt0;
    int ret_cnt1;
    bit rb;
    bit rh;
    rst = 1'b1;
    en = 1'b0;
    start_game = 1'b0;
    button = 1'b0;
    hittable_ball = 1'b0;
    for (int d = 0; d < 2; d++) m_en_cyc[d] = 0;
    @(negedge clk);
    resetPulse();

    // Hit, then a held button must not return again
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    ret_cnt0 = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1, 1, 1);
      ret_cnt0 += int'(ret0);
    end
    checkOutput("hit_ret_count", ret_cnt0, 1);
    checkOutput("hit_life", int'(life0), 3);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);

    // Three whiffs spaced six cycles apart exhaust dut0
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0);
      checkOutput($sformatf("whiff%0d_life", k), int'(life0), 2 - k);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    end
    checkOutput("whiff_match", int'(match0), 1);
    applyStimulus(0, 0, 0);
    checkOutput("newgame_life", int'(life0), 3);
    checkOutput("newgame_match", int'(match0), 0);

    // A press during cooldown inside a window is ignored; the window is missed
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("cooldown_ret", int'(ret0), 0);
    checkOutput("cooldown_life", int'(life0), 2);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("cooldown_miss_match", int'(match0), 1);
    applyStimulus(0, 0, 0);

    // Two unanswered windows cost dut1 both lives
    applyStimulus(1, 0, 0);
    ret_cnt1 = 0;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1, 0, 1);
        ret_cnt1 += int'(ret1);
      end
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("miss%0d_life", w), int'(life1), 1 - w);
      applyStimulus(1, 0, 0);
    end
    checkOutput("miss_match", int'(match1), 1);
    checkOutput("miss_ret_count", ret_cnt1, 0);
    applyStimulus(0, 0, 0);

    // Press on the rising edge of the window is a hit
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("rise_press_ret", int'(ret0), 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);

    // Press on the falling edge of the window is a miss only
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 0);
    checkOutput("fall_press_life1", int'(life1), 1);
    checkOutput("fall_press_cooling1", int'(cooling1), 0);
    checkOutput("fall_press_match0", int'(match0), 1);
    applyStimulus(0, 0, 0);

    // Freeze mid-window with the button toggling
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, (i % 2) == 0, 0, 0);
      checkOutput("freeze_ret", int'(ret0), 0);
    end
    checkOutput("freeze_life", int'(life0), 3);
    checkOutput("freeze_match", int'(match0), 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("after_freeze_ret", int'(ret0), 1);
    applyStimulus(1, 0, 0);

    // Miss into OVER, then asynchronous reset
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("pre_reset_match", int'(match0), 1);
    resetPulse();

    // Randomized run
    rb = 0;
    rh = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        resetPulse();
      end else begin
        if ($urandom_range(0, 5) == 0) rh = !rh;
        if ($urandom_range(0, 2) == 0) rb = !rb;
        applyStimulus($urandom_range(0, 99) != 0, rb, rh, $urandom_range(0, 7) != 0);
      end
    end

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
